// File: rtl/sdram_port_arb.sv
// sdram_port_arb: round-robin arbiter that shares one SDRAM controller port between two pulse/ready requesters
module sdram_port_arb #(
  parameter int AW = 25,
  parameter int DW = 32,
  parameter int BW = 4
) (
  input  logic          SDRAM_CLK,
  input  logic          RESET,
  input  logic          A_CLKREF,
  input  logic [AW-1:0] A_WADDR,
  input  logic [DW-1:0] A_DIN,
  input  logic [BW-1:0] A_BE,
  input  logic          A_WE,
  input  logic          A_RD,
  input  logic [AW-1:0] A_RADDR,
  output logic          A_WE_RDY,
  output logic          A_RD_RDY,
  output logic [DW-1:0] A_DOUT,
  input  logic          B_CLKREF,
  input  logic [AW-1:0] B_WADDR,
  input  logic [DW-1:0] B_DIN,
  input  logic [BW-1:0] B_BE,
  input  logic          B_WE,
  input  logic          B_RD,
  input  logic [AW-1:0] B_RADDR,
  output logic          B_WE_RDY,
  output logic          B_RD_RDY,
  output logic [DW-1:0] B_DOUT,
  output logic          SDRAM_CLKREF,
  output logic [AW-1:0] SDRAM_WADDR,
  output logic [DW-1:0] SDRAM_DIN,
  output logic [BW-1:0] SDRAM_BE,
  output logic          SDRAM_WE,
  output logic          SDRAM_RD,
  output logic [AW-1:0] SDRAM_RADDR,
  input  logic          SDRAM_WE_RDY,
  input  logic          SDRAM_RD_RDY,
  input  logic [DW-1:0] SDRAM_DOUT
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] rd, we, cap, req, pend, n_we, p_we;
  logic [AW-1:0] in_waddr [2], in_raddr [2], n_addr [2], p_addr [2];
  logic [DW-1:0] in_din [2], n_din [2], p_din [2], dout [2];
  logic [BW-1:0] in_be [2], n_be [2], p_be [2];
  logic sel, last_grant, g_port, g_we, issue, finish;
  assign rd = {B_RD, A_RD};
  assign we = {B_WE, A_WE};
  assign in_waddr[0] = A_WADDR;
  assign in_waddr[1] = B_WADDR;
  assign in_raddr[0] = A_RADDR;
  assign in_raddr[1] = B_RADDR;
  assign in_din[0] = A_DIN;
  assign in_din[1] = B_DIN;
  assign in_be[0] = A_BE;
  assign in_be[1] = B_BE;
  // A fresh pulse is visible to the grant logic in the cycle it arrives, so n_* is the effective request
  always_comb
    for (int i = 0; i < 2; i++) begin
      cap[i] = ~pend[i] & (rd[i] | we[i]);
      n_we[i] = cap[i] ? we[i] : p_we[i];
      n_addr[i] = !cap[i] ? p_addr[i] : we[i] ? in_waddr[i] : in_raddr[i];
      n_din[i] = cap[i] ? in_din[i] : p_din[i];
      n_be[i] = cap[i] ? in_be[i] : p_be[i];
    end
  assign req = pend | cap;
  assign sel = &req ? ~last_grant : req[1];
  assign issue = state == IDLE && |req && SDRAM_RD_RDY && SDRAM_WE_RDY;
  assign finish = state == WAIT && (g_we ? SDRAM_WE_RDY : SDRAM_RD_RDY);
  always_ff @(posedge SDRAM_CLK)
    state <= RESET ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE  ? (issue ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (finish ? DONE : WAIT) : IDLE;
  always_comb begin
    A_WE_RDY = ~pend[0];
    A_RD_RDY = ~pend[0];
    B_WE_RDY = ~pend[1];
    B_RD_RDY = ~pend[1];
    A_DOUT = dout[0];
    B_DOUT = dout[1];
    SDRAM_CLKREF = A_CLKREF | B_CLKREF;
  end
  always_ff @(posedge SDRAM_CLK) begin
    p_we <= n_we;
    p_addr <= n_addr;
    p_din <= n_din;
    p_be <= n_be;
    if (RESET) begin
      pend <= '0;
      last_grant <= 1'b1;
      g_port <= 1'b0;
      g_we <= 1'b0;
      SDRAM_RD <= 1'b0;
      SDRAM_WE <= 1'b0;
      SDRAM_WADDR <= '0;
      SDRAM_RADDR <= '0;
      SDRAM_DIN <= '0;
      SDRAM_BE <= '0;
      dout <= '{default: '0};
    end else begin
      // Pend drops on the completion edge so the port shows ready in DONE and may re-request there
      for (int i = 0; i < 2; i++)
        pend[i] <= req[i] & ~(finish && g_port == i[0]);
      SDRAM_RD <= issue & ~n_we[sel];
      SDRAM_WE <= issue & n_we[sel];
      if (issue) begin
        last_grant <= sel;
        g_port <= sel;
        g_we <= n_we[sel];
        if (n_we[sel]) begin
          SDRAM_WADDR <= n_addr[sel];
          SDRAM_DIN <= n_din[sel];
          SDRAM_BE <= n_be[sel];
        end else
          SDRAM_RADDR <= n_addr[sel];
      end
      if (finish && !g_we)
        dout[g_port] <= SDRAM_DOUT;
    end
  end
endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Two-requester arbiter in front of the single MiSTer SDRAM controller port.
- Port A is the CPU memory interface (ROM/RAM/SRAM path). Port B is the auxiliary channel: ROM download / backup-RAM (BMP region) load and save.
- Each upstream port sees the same pulse/ready protocol the controller presents. The arbiter captures requests, serializes them round-robin, and returns per-port held read data.

Parameters:
- AW, 25, SDRAM word address width
- DW, 32, data width
- BW, 4, byte-enable width (DW/8)

Ports:
- SDRAM_CLK  in  1  sole clock; all logic on its rising edge
- RESET  in  1  synchronous, active-high reset
- A_CLKREF  in  1  port A clock-reference strobe
- A_WADDR  in  AW  port A write address
- A_DIN  in  DW  port A write data
- A_BE  in  BW  port A byte enables
- A_WE  in  1  port A write request pulse
- A_RD  in  1  port A read request pulse
- A_RADDR  in  AW  port A read address
- A_WE_RDY  out  1  port A idle/write done
- A_RD_RDY  out  1  port A idle/read done
- A_DOUT  out  DW  port A held read data
- B_*  same nine signals as port A, for port B
- SDRAM_CLKREF  out  1  A_CLKREF | B_CLKREF (combinational)
- SDRAM_WADDR, SDRAM_DIN, SDRAM_BE, SDRAM_WE, SDRAM_RD, SDRAM_RADDR  out  AW/DW/BW/1/1/AW  to controller, all registered
- SDRAM_WE_RDY, SDRAM_RD_RDY  in  1  controller ready
- SDRAM_DOUT  in  DW  controller read data

Behaviour:
- Downstream contract: a 1-cycle RD/WE pulse is accepted only while the matching RDY is high. RDY falls no later than the cycle after the pulse. RDY rising marks completion; SDRAM_DOUT is valid in that cycle.
- Per-port capture: a pulse on xRD or xWE latches op, address, DIN and BE into a pending register and sets pend_x.
  - Read captures RADDR; write captures WADDR, DIN and BE.
  - If RD and WE pulse together, the write wins and the read is dropped.
  - Pulses while the port is pending or in flight are ignored. This is a protocol violation; the pending contents must not change.
- Upstream ready: xWE_RDY and xRD_RDY are both low from the cycle after capture until completion. Otherwise both are high.
- FSM states: IDLE, ISSUE, WAIT, DONE. Register last_grant resets to B.
- IDLE:
  - Stays in IDLE unless a pend flag is set and (SDRAM_RD_RDY & SDRAM_WE_RDY).
  - Selection: if only one port is pending, grant it. If both are pending, grant the port that is not last_grant.
  - On grant, drive a 1-cycle SDRAM_RD or SDRAM_WE pulse with the captured fields, update last_grant, and go to ISSUE.
- ISSUE: one cycle; the controller RDY may still be high here and is ignored. Go to WAIT.
- WAIT: hold until the granted op's SDRAM RDY is high. On that cycle, latch SDRAM_DOUT into xDOUT (reads only) and go to DONE.
- DONE: clear pend_x, raise the granted port's RDY pair (registered, visible this cycle), and return to IDLE.
- Latency:
  - Uncontended, port pulse at cycle N: downstream pulse at N+1.
  - Downstream completion at cycle M: port RDY high at M+1.
  - xDOUT is valid from M+1 and holds until that port's next read completes. The other port's traffic never alters it.
- SDRAM_* address, data and BE hold their last issued value between pulses. SDRAM_RD/WE are 0 except the single issue cycle.
- A request captured in the same cycle the arbiter returns to IDLE is eligible that cycle.
- Starvation bound: while both ports are continuously requesting, service strictly alternates.
- Reset (also when asserted mid-transfer):
  - Cleared: state IDLE, pend_A/pend_B, SDRAM_RD/WE 0, last_grant B, port RDYs high.
  - xDOUT resets to 0; SDRAM address, data and BE reset to 0.
  - An in-flight controller op is abandoned. IDLE does not issue until both SDRAM RDYs are high, so the controller drains safely.

Test Plan:
- Single read A: A_RADDR=0x0100040, A_RD pulse at cycle 10; controller stub has 6-cycle latency, DOUT=0xDEADBEEF.
  -> SDRAM_RD pulse at 11 with RADDR=0x0100040; A_RD_RDY low 11..17 and high at 18; A_DOUT=0xDEADBEEF; B ready stays high throughout.
- Collision: A read and B write (WADDR=0x0900010, DIN=0x12345678, BE=0x3) pulse in the same cycle after reset.
  -> A is issued first (last_grant=B); B's write is issued in the IDLE cycle right after A's DONE with unchanged fields.
- Alternation: both ports re-request immediately on every completion for 8 transfers.
  -> issue order is A,B,A,B,...; B's read data never appears on A_DOUT and vice versa.
- Busy controller: hold SDRAM_RD_RDY low for 20 cycles with A pending.
  -> no SDRAM pulse until RDY is high; A_RD_RDY stays low for the whole interval.
- Protocol violation: second A_RD pulse with a new address while A is in flight.
  -> ignored; only the original address is issued; exactly one completion occurs.
- Reset in WAIT: assert RESET for 1 cycle mid-read, with the controller RDY still low for 3 more cycles.
  -> all port RDYs high and pend flags clear after reset; a new B read is not issued until both SDRAM RDYs are high.
